// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared instruction/data memory between fetch (IF) and load/store (LS); LS wins.
// Sub-word stores are read-modify-write. Define MEM_ALIGN_CHECK_EN to add the ls_err port.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_done,
    output logic [31:0] ls_rdata,
`ifdef MEM_ALIGN_CHECK_EN
    output logic        ls_err,
`endif
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);
    localparam int unsigned CntW = $clog2(MEM_LAT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_LAT - 1);

    typedef enum logic [1:0] {StIdle, StRdWait, StRmwRd, StWrite} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            owner_if_q, owner_if_d;
    logic [1:0]      lane_q, lane_d;
    logic [1:0]      size_q, size_d;
    logic [15:0]     wdata_q, wdata_d;
    logic            if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d;
    logic            ls_gnt_q, ls_gnt_d, ls_done_q, ls_done_d;
    logic [31:0]     if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
    logic [31:0]     mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic            mem_wr_q, mem_wr_d, busy_q, busy_d;
    logic            ls_word, ls_misaligned, cnt_last;
    logic [31:0]     merged;
    logic            unused_if_lo;

    assign unused_if_lo = ^if_addr[1:0];
    assign ls_word      = (ls_size != 2'b01) && (ls_size != 2'b10);
    assign cnt_last     = (cnt_q == CntLast);

`ifdef MEM_ALIGN_CHECK_EN
    logic err_pend_q, err_pend_d, ls_err_q, ls_err_d;
    assign ls_misaligned = (ls_word && (ls_addr[1:0] != 2'b00)) ||
                           ((ls_size == 2'b01) && ls_addr[0]);
    assign ls_err        = ls_err_q;
`else
    assign ls_misaligned = 1'b0;
`endif

    // Lane merge of the latched store data into the word just read back.
    always_comb begin
        merged = mem_rdata;
        if (size_q == 2'b10) begin
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_if_d  = owner_if_q;
        lane_d      = lane_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        ls_rdata_d  = ls_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_gnt_d    = 1'b0;
        if_rvalid_d = 1'b0;
        ls_gnt_d    = 1'b0;
        ls_done_d   = 1'b0;
        mem_wr_d    = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        err_pend_d  = err_pend_q;
        ls_err_d    = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (ls_req) begin
                    ls_gnt_d   = 1'b1;
                    owner_if_d = 1'b0;
                    mem_addr_d = {ls_addr[31:2], 2'b00};
                    lane_d     = ls_addr[1:0];
                    size_d     = ls_size;
                    wdata_d    = ls_wdata[15:0];
                    if (ls_misaligned) begin
                        // No memory access; StWrite only produces the done/err pulse.
                        state_d = StWrite;
`ifdef MEM_ALIGN_CHECK_EN
                        err_pend_d = 1'b1;
`endif
                    end else if (!ls_we) begin
                        state_d = StRdWait;
                    end else if (ls_word) begin
                        state_d     = StWrite;
                        mem_wr_d    = 1'b1;
                        mem_wdata_d = ls_wdata;
                    end else begin
                        state_d = StRmwRd;
                    end
                end else if (if_req) begin
                    if_gnt_d   = 1'b1;
                    owner_if_d = 1'b1;
                    mem_addr_d = {if_addr[31:2], 2'b00};
                    state_d    = StRdWait;
                end
            end
            StRdWait: begin
                if (cnt_last) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                    if (owner_if_q) begin
                        if_rdata_d  = mem_rdata;
                        if_rvalid_d = 1'b1;
                    end else begin
                        ls_rdata_d = mem_rdata;
                        ls_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRmwRd: begin
                if (cnt_last) begin
                    cnt_d       = '0;
                    state_d     = StWrite;
                    mem_wr_d    = 1'b1;
                    mem_wdata_d = merged;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWrite: begin
                cnt_d     = '0;
                state_d   = StIdle;
                ls_done_d = 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
                ls_err_d   = err_pend_q;
                err_pend_d = 1'b0;
`endif
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            owner_if_q  <= 1'b0;
            lane_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            if_gnt_q    <= 1'b0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            ls_gnt_q    <= 1'b0;
            ls_done_q   <= 1'b0;
            ls_rdata_q  <= '0;
            mem_addr_q  <= '0;
            mem_wr_q    <= 1'b0;
            mem_wdata_q <= '0;
            busy_q      <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            err_pend_q  <= 1'b0;
            ls_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_if_q  <= owner_if_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            if_gnt_q    <= if_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            ls_gnt_q    <= ls_gnt_d;
            ls_done_q   <= ls_done_d;
            ls_rdata_q  <= ls_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wr_q    <= mem_wr_d;
            mem_wdata_q <= mem_wdata_d;
            busy_q      <= busy_d;
`ifdef MEM_ALIGN_CHECK_EN
            err_pend_q  <= err_pend_d;
            ls_err_q    <= ls_err_d;
`endif
        end
    end

    assign if_gnt    = if_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign ls_gnt    = ls_gnt_q;
    assign ls_done   = ls_done_q;
    assign ls_rdata  = ls_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wr    = mem_wr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-level model compared every cycle, plus directed
// literal checks. Honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_port_arbiter;
    localparam int unsigned MEM_LAT = 3;
    localparam int K_FETCH = 0, K_LOAD = 1, K_SW = 2, K_SUB = 3, K_ERR = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_done;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_wr, busy;
    logic        ls_err;

    logic [31:0] mem     [0:1023];
    logic [31:0] ref_mem [0:1023];

    mem_port_arbiter #(.MEM_LAT(MEM_LAT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_gnt(ls_gnt), .ls_done(ls_done), .ls_rdata(ls_rdata),
`ifdef MEM_ALIGN_CHECK_EN
        .ls_err(ls_err),
`endif
        .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy)
    );

`ifndef MEM_ALIGN_CHECK_EN
    assign ls_err = 1'b0;
`endif

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] mem_init(input int i);
        case (i)
            16:      return 32'h8C22_0004;
            17:      return 32'h2442_0001;
            64:      return 32'h1122_3344;
            65:      return 32'h5566_7788;
            128:     return 32'h0000_0000;
            default: return (i * 32'h0001_0001) ^ 32'hA5A5_0000;
        endcase
    endfunction

    function automatic logic [31:0] mdl_merge(input logic [31:0] old, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] wd);
        int sh;
        logic [31:0] mask;
        if (size == 2'b10) begin
            sh = 8 * int'(addr % 4);
            mask = 32'hFF << sh;
        end else begin
            sh = 16 * int'((addr / 2) % 2);
            mask = 32'hFFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    // Memory: combinational read, write on the edge that ends a mem_wr cycle.
    assign mem_rdata = mem[mem_addr[11:2]];
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = mem_init(i);
        forever begin
            @(posedge clk);
            if (mem_wr === 1'b1) mem[mem_addr[11:2]] = mem_wdata;
        end
    end

    // Transaction model: grant edge g, completion edge g+fin, derived from the rules directly.
    logic        exp_if_gnt, exp_if_rvalid, exp_ls_gnt, exp_ls_done, exp_mem_wr, exp_busy;
    logic        exp_ls_err;
    logic [31:0] exp_if_rdata, exp_ls_rdata, exp_mem_addr, exp_mem_wdata;
    logic [31:0] m_addr, m_wdata;
    logic [1:0]  m_size;
    bit          m_act = 1'b0, started = 1'b0;
    int          m_edge = 0, m_g = 0, m_fin = 0, m_kind = 0;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = mem_init(i);
        forever begin
            @(posedge clk);
            started = 1'b1;
            m_edge++;
            exp_if_gnt = 0; exp_ls_gnt = 0; exp_if_rvalid = 0; exp_ls_done = 0;
            exp_mem_wr = 0; exp_ls_err = 0;
            if (reset) begin
                m_act = 1'b0;
                exp_if_rdata = 0; exp_ls_rdata = 0; exp_mem_addr = 0; exp_mem_wdata = 0;
            end else if (m_act) begin
                if (m_edge == m_g + m_fin) begin
                    m_act = 1'b0;
                    case (m_kind)
                        K_FETCH: begin exp_if_rvalid = 1; exp_if_rdata = ref_mem[m_addr[11:2]]; end
                        K_LOAD:  begin exp_ls_done = 1; exp_ls_rdata = ref_mem[m_addr[11:2]]; end
                        K_SW:    begin exp_ls_done = 1; ref_mem[m_addr[11:2]] = m_wdata; end
                        K_SUB: begin
                            exp_ls_done = 1;
                            ref_mem[m_addr[11:2]] =
                                mdl_merge(ref_mem[m_addr[11:2]], m_addr, m_size, m_wdata);
                        end
                        default: begin exp_ls_done = 1; exp_ls_err = 1; end
                    endcase
                end else if (m_kind == K_SUB && m_edge == m_g + int'(MEM_LAT)) begin
                    exp_mem_wr = 1;
                    exp_mem_wdata = mdl_merge(ref_mem[m_addr[11:2]], m_addr, m_size, m_wdata);
                end
            end else if (ls_req) begin
                m_act = 1; m_g = m_edge; m_addr = ls_addr; m_size = ls_size; m_wdata = ls_wdata;
                exp_ls_gnt = 1;
                exp_mem_addr = ls_addr & 32'hFFFF_FFFC;
                if (!ls_we) begin
                    m_kind = K_LOAD; m_fin = int'(MEM_LAT);
                end else if (ls_size == 2'b01 || ls_size == 2'b10) begin
                    m_kind = K_SUB; m_fin = int'(MEM_LAT) + 1;
                end else begin
                    m_kind = K_SW; m_fin = 1; exp_mem_wr = 1; exp_mem_wdata = ls_wdata;
                end
`ifdef MEM_ALIGN_CHECK_EN
                if (((ls_size == 2'b00 || ls_size == 2'b11) && ls_addr % 4 != 0) ||
                    (ls_size == 2'b01 && ls_addr % 2 != 0)) begin
                    m_kind = K_ERR; m_fin = 1; exp_mem_wr = 0;
                end
`endif
            end else if (if_req) begin
                m_act = 1; m_g = m_edge; m_addr = if_addr; m_kind = K_FETCH;
                m_fin = int'(MEM_LAT);
                exp_if_gnt = 1;
                exp_mem_addr = if_addr & 32'hFFFF_FFFC;
            end
            exp_busy = m_act;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk("if_gnt", 32'(if_gnt), 32'(exp_if_gnt));
                chk("if_rvalid", 32'(if_rvalid), 32'(exp_if_rvalid));
                chk("if_rdata", if_rdata, exp_if_rdata);
                chk("ls_gnt", 32'(ls_gnt), 32'(exp_ls_gnt));
                chk("ls_done", 32'(ls_done), 32'(exp_ls_done));
                chk("ls_rdata", ls_rdata, exp_ls_rdata);
                chk("mem_addr", mem_addr, exp_mem_addr);
                chk("mem_wr", 32'(mem_wr), 32'(exp_mem_wr));
                chk("busy", 32'(busy), 32'(exp_busy));
                if (exp_mem_wr) chk("mem_wdata", mem_wdata, exp_mem_wdata);
`ifdef MEM_ALIGN_CHECK_EN
                chk("ls_err", 32'(ls_err), 32'(exp_ls_err));
`endif
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic ls_issue(input logic we, input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] wd);
        ls_req = 1'b1; ls_we = we; ls_size = sz; ls_addr = a; ls_wdata = wd;
    endtask

    initial begin
        reset = 1'b1; if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = '0; ls_addr = '0; ls_wdata = '0;
        cyc(2);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;

        // fetch 0x40
        if_req = 1'b1; if_addr = 32'h40;
        cyc(1); chk("t1_gnt", 32'(if_gnt), 32'd1); if_req = 1'b0;
        cyc(2); chk("t1_rvalid_early", 32'(if_rvalid), 32'd0);
        cyc(1); chk("t1_rvalid", 32'(if_rvalid), 32'd1);
        chk("t1_rdata", if_rdata, 32'h8C22_0004);
        cyc(1);

        // simultaneous requests: LS first, IF granted on the edge ending ls_done
        if_req = 1'b1; if_addr = 32'h44; ls_issue(1'b0, 2'b00, 32'h100, 32'h0);
        cyc(1); chk("t2_ls_gnt", 32'(ls_gnt), 32'd1); chk("t2_if_gnt0", 32'(if_gnt), 32'd0);
        ls_req = 1'b0;
        cyc(3); chk("t2_ls_done", 32'(ls_done), 32'd1); chk("t2_ls_rdata", ls_rdata, 32'h1122_3344);
        cyc(1); chk("t2_if_gnt", 32'(if_gnt), 32'd1); if_req = 1'b0;
        cyc(3); chk("t2_if_rvalid", 32'(if_rvalid), 32'd1);
        chk("t2_if_rdata", if_rdata, 32'h2442_0001);
        cyc(1);

        // sb 0x102 <- 0xAB
        ls_issue(1'b1, 2'b10, 32'h102, 32'hFFFF_FFAB);
        cyc(1); ls_req = 1'b0;
        cyc(3); chk("t3_mem_wr", 32'(mem_wr), 32'd1); chk("t3_wdata", mem_wdata, 32'h11AB_3344);
        cyc(1); chk("t3_done", 32'(ls_done), 32'd1); chk("t3_wr_off", 32'(mem_wr), 32'd0);
        cyc(1); chk("t3_mem", mem[64], 32'h11AB_3344);

        // sh 0x106 <- 0xCAFE
        ls_issue(1'b1, 2'b01, 32'h106, 32'h1234_CAFE);
        cyc(1); ls_req = 1'b0;
        cyc(3); chk("sh_wdata", mem_wdata, 32'hCAFE_7788);
        cyc(2); chk("sh_mem", mem[65], 32'hCAFE_7788);

        // sw 0x200 <- 0xDEADBEEF
        ls_issue(1'b1, 2'b00, 32'h200, 32'hDEAD_BEEF);
        cyc(1); ls_req = 1'b0;
        chk("t4_mem_wr", 32'(mem_wr), 32'd1); chk("t4_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("t4_addr", mem_addr, 32'h200);
        cyc(1); chk("t4_done", 32'(ls_done), 32'd1);
        cyc(1); chk("t4_mem", mem[128], 32'hDEAD_BEEF);

        // sb top lane 0x203 <- 0x5A
        ls_issue(1'b1, 2'b10, 32'h203, 32'h0000_005A);
        cyc(1); ls_req = 1'b0;
        cyc(3); chk("sb3_wdata", mem_wdata, 32'h5AAD_BEEF);
        cyc(2);

        // held load request: back-to-back grants with no dead cycle
        ls_issue(1'b0, 2'b00, 32'h200, 32'h0);
        cyc(4); chk("b2b_rdata", ls_rdata, 32'h5AAD_BEEF);
        cyc(1); chk("b2b_gnt", 32'(ls_gnt), 32'd1); ls_req = 1'b0;
        cyc(4);

        // reset on E1 of a fetch
        if_req = 1'b1; if_addr = 32'h40;
        cyc(1); if_req = 1'b0; reset = 1'b1;
        cyc(1); chk("t5_busy", 32'(busy), 32'd0); chk("t5_if_rdata", if_rdata, 32'd0);
        chk("t5_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        cyc(4);
        if_req = 1'b1; if_addr = 32'h44;
        cyc(1); chk("t5_gnt", 32'(if_gnt), 32'd1); if_req = 1'b0;
        cyc(3); chk("t5_rvalid", 32'(if_rvalid), 32'd1); chk("t5_rdata", if_rdata, 32'h2442_0001);
        cyc(1);

        // lw 0x102: misaligned error, or masked to 0x100
        ls_issue(1'b0, 2'b00, 32'h102, 32'h0);
        cyc(1); ls_req = 1'b0; chk("t6_addr", mem_addr, 32'h100);
`ifdef MEM_ALIGN_CHECK_EN
        cyc(1); chk("t6_err", 32'(ls_err), 32'd1); chk("t6_done", 32'(ls_done), 32'd1);
        chk("t6_rdata", ls_rdata, 32'd0);
`else
        cyc(3); chk("t6_done", 32'(ls_done), 32'd1); chk("t6_rdata", ls_rdata, 32'h11AB_3344);
        chk("t6_err", 32'(ls_err), 32'd0);
`endif
        cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
